// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: datapath widths, FSM
// state encodings and the upper bound on configurable access latency.
package mem_access_stage_pkg;

  localparam int LEN_DATA     = 32;
  localparam int LEN_INST_REG = 5;
  localparam int MEM_LAT_MAX  = 7;
  localparam int MEM_CNT_W    = $clog2(MEM_LAT_MAX + 1);

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_data_mem_array.sv
// Word-addressed data memory: synchronous write, registered synchronous read.
// Read register clears on reset; array contents survive reset.
module data_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: multi-cycle data memory access with upstream stall and
// write-back bubble insertion; WB control and ALU result pass straight through.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W  = LEN_DATA,
  parameter int REG_W   = LEN_INST_REG,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_MemRead,
  input  logic              i_MemWrite,
  input  logic              i_RegWrite,
  input  logic              i_MemToReg,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic [REG_W-1:0]  i_rd,
  output logic              o_RegWrite,
  output logic              o_MemToReg,
  output logic [DATA_W-1:0] o_mem_data,
  output logic [DATA_W-1:0] o_alu_data,
  output logic [REG_W-1:0]  o_rd,
  output logic              o_stall,
  output logic              o_misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [MEM_CNT_W-1:0] LAT_M1 = MEM_CNT_W'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > MEM_LAT_MAX) begin : g_bad_latency
    $error("mem_access_stage: LATENCY out of range 1..7");
  end

  mem_state_e            state_q, state_d;
  logic [MEM_CNT_W-1:0]  cnt_q;
  logic                  wr_q;
  logic [AW-1:0]         idx_q;
  logic [DATA_W-1:0]     wdata_q;

  logic req, misaligned, aligned_req, cnt_zero;
  logic stall, mem_we, mem_re;

  assign req         = i_MemRead | i_MemWrite;
  assign misaligned  = req & (i_alu_data[1:0] != 2'b00);
  assign aligned_req = req & ~misaligned;
  assign cnt_zero    = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= MEM_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (aligned_req) state_d = MEM_WAIT;
      MEM_WAIT: if (cnt_zero)    state_d = MEM_DONE;
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // Stall is raised in the accepting IDLE cycle itself so EX/MEM holds the op.
  always_comb begin
    stall  = 1'b0;
    mem_we = 1'b0;
    mem_re = 1'b0;
    if (!rst) begin
      case (state_q)
        MEM_IDLE: stall = aligned_req;
        MEM_WAIT: begin
          stall  = 1'b1;
          mem_we = cnt_zero & wr_q;
          mem_re = cnt_zero & ~wr_q;
        end
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      wr_q  <= 1'b0;
    end else if (state_q == MEM_IDLE && aligned_req) begin
      cnt_q <= LAT_M1;
      wr_q  <= i_MemWrite;
    end else if (state_q == MEM_WAIT && !cnt_zero) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == MEM_IDLE && aligned_req) begin
      idx_q   <= i_alu_data[AW+1:2];
      wdata_q <= i_write_data;
    end
  end

  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (o_mem_data)
  );

  assign o_stall      = stall;
  assign o_misaligned = misaligned & ~rst;
  assign o_RegWrite   = i_RegWrite & ~stall & ~o_misaligned & ~rst;
  assign o_MemToReg   = i_MemToReg;
  assign o_alu_data   = i_alu_data;
  assign o_rd         = i_rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed instructions push expected
// retirement values; a negedge monitor checks stall cycles and retired outputs.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_MemRead, i_MemWrite, i_RegWrite, i_MemToReg;
  logic [31:0] i_alu_data, i_write_data;
  logic [4:0]  i_rd;
  logic        o_RegWrite, o_MemToReg, o_stall, o_misaligned;
  logic [31:0] o_mem_data, o_alu_data;
  logic [4:0]  o_rd;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        regw;
    logic        mis;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] mem;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  logic tb_vld = 1'b0;
  int   stall_cnt = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .DATA_W(32), .REG_W(5), .DEPTH(256), .LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite),
    .i_RegWrite(i_RegWrite), .i_MemToReg(i_MemToReg),
    .i_alu_data(i_alu_data), .i_write_data(i_write_data), .i_rd(i_rd),
    .o_RegWrite(o_RegWrite), .o_MemToReg(o_MemToReg),
    .o_mem_data(o_mem_data), .o_alu_data(o_alu_data), .o_rd(o_rd),
    .o_stall(o_stall), .o_misaligned(o_misaligned)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: stall cycles must block RegWrite; a non-stalled cycle retires the op.
  always @(negedge clk) begin
    if (tb_vld && !rst) begin
      if (o_stall) begin
        stall_cnt++;
        chk("stall_regwrite", {31'b0, o_RegWrite}, 32'd0);
      end else if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("regwrite", {31'b0, o_RegWrite}, {31'b0, e.regw});
        chk("misaligned", {31'b0, o_misaligned}, {31'b0, e.mis});
        chk("alu_data", o_alu_data, e.alu);
        chk("rd", {27'b0, o_rd}, {27'b0, e.rd});
        chk("mem_data", o_mem_data, e.mem);
        chk("stall_cycles", stall_cnt, e.stalls);
        stall_cnt = 0;
      end
    end
  end

  task automatic idle_inputs();
    i_MemRead = 0; i_MemWrite = 0; i_RegWrite = 0; i_MemToReg = 0;
    i_alu_data = 0; i_write_data = 0; i_rd = 0;
  endtask

  // Drives one instruction (called just after a posedge) and holds it until retirement.
  task automatic issue(input logic mr, input logic mw, input logic regw, input logic m2r,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rdi,
                       input logic exp_regw, input logic exp_mis, input int exp_stalls,
                       input logic [31:0] exp_mem);
    exp_t e;
    bit   done = 0;
    e.regw = exp_regw; e.mis = exp_mis; e.alu = addr; e.rd = rdi;
    e.mem = exp_mem; e.stalls = exp_stalls;
    i_MemRead = mr; i_MemWrite = mw; i_RegWrite = regw; i_MemToReg = m2r;
    i_alu_data = addr; i_write_data = wd; i_rd = rdi;
    exp_q.push_back(e);
    tb_vld = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!o_stall) done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL retire_timeout actual=stalled required=retire addr=%h", addr);
      exp_q.delete();
    end
    @(posedge clk); #1;
    tb_vld = 0;
    stall_cnt = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    i_MemRead = 1; i_RegWrite = 1; i_alu_data = 32'h10;
    @(posedge clk); @(negedge clk);
    chk("rst_stall", {31'b0, o_stall}, 32'd0);
    chk("rst_regwrite", {31'b0, o_RegWrite}, 32'd0);
    chk("rst_mem_data", o_mem_data, 32'd0);
    i_alu_data = 32'h13;
    @(negedge clk);
    chk("rst_misaligned", {31'b0, o_misaligned}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();
    @(posedge clk); #1;

    //     mr mw rw m2r addr          wdata         rd  ergw emis st  emem
    issue(0, 1, 0, 0, 32'h10,       32'hDEADBEEF, 0,  0,   0,   3,  32'h0);
    issue(1, 0, 1, 1, 32'h10,       32'h0,        3,  1,   0,   3,  32'hDEADBEEF);
    issue(0, 0, 1, 0, 32'h1234,     32'h0,        7,  1,   0,   0,  32'hDEADBEEF);
    issue(1, 0, 1, 1, 32'h13,       32'h0,        4,  0,   1,   0,  32'hDEADBEEF);
    issue(1, 0, 1, 1, 32'h10,       32'h0,        5,  1,   0,   3,  32'hDEADBEEF);
    issue(0, 1, 0, 0, 32'h20,       32'hA5,       0,  0,   0,   3,  32'hDEADBEEF);

    // Store of 0x55 to 0x20, aborted by reset in its first WAIT cycle.
    i_MemWrite = 1; i_alu_data = 32'h20; i_write_data = 32'h55;
    @(negedge clk);
    chk("abort_idle_stall", {31'b0, o_stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1;
    idle_inputs();
    i_RegWrite = 1;
    @(negedge clk);
    chk("abort_rst_stall", {31'b0, o_stall}, 32'd0);
    chk("abort_rst_regwrite", {31'b0, o_RegWrite}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("abort_after_stall", {31'b0, o_stall}, 32'd0);
    chk("abort_after_regwrite", {31'b0, o_RegWrite}, 32'd1);
    chk("abort_after_mem_data", o_mem_data, 32'd0);
    @(posedge clk); #1;
    idle_inputs();

    issue(1, 0, 1, 1, 32'h20,       32'h0,        9,  1,   0,   3,  32'hA5);
    issue(0, 1, 0, 0, 32'h400,      32'hCAFE0001, 0,  0,   0,   3,  32'hA5);
    issue(1, 0, 1, 1, 32'h0,        32'h0,        10, 1,   0,   3,  32'hCAFE0001);
    issue(1, 1, 0, 0, 32'h30,       32'h77,       0,  0,   0,   3,  32'hCAFE0001);
    issue(1, 0, 1, 1, 32'h30,       32'h0,        11, 1,   0,   3,  32'h77);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
